// File: rtl/keypad_tick_display_unit_if.sv
// Bundles the divider, display and key-matrix signals of the keypad/tick/display block.
// The master side drives the controls and the matrix rows; the slave side is the block itself.
interface keypad_tick_display_unit_if;
  logic [27:0] counter_max;
  logic        div_enable;
  logic [27:0] counter;
  logic        tick;
  logic [3:0]  binary;
  logic        dec_enable;
  logic [6:0]  hex;
  logic [2:0]  row;
  logic [2:0]  column;
  logic [3:0]  key;
  logic        valid_key;

  modport master (
    output counter_max, div_enable, binary, dec_enable, row,
    input  counter, tick, hex, column, key, valid_key
  );

  modport slave (
    input  counter_max, div_enable, binary, dec_enable, row,
    output counter, tick, hex, column, key, valid_key
  );
endinterface

// File: rtl/keypad_tick_display_unit.sv
// Shared I/O block for the whack-a-mole game: a tick divider, a 7-segment digit register,
// and a debounced 3x3 key-matrix scanner. The three parts share only clock and reset.
module keypad_tick_display_unit #(
  parameter int SCAN_CYCLES    = 50_000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic reset,
  keypad_tick_display_unit_if.slave bus
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_SCANS);

  function automatic logic [6:0] segPattern(input logic [3:0] value);
    case (value)
      4'd0:    segPattern = 7'b1000000;
      4'd1:    segPattern = 7'b1111001;
      4'd2:    segPattern = 7'b0100100;
      4'd3:    segPattern = 7'b0110000;
      4'd4:    segPattern = 7'b0011001;
      4'd5:    segPattern = 7'b0010010;
      4'd6:    segPattern = 7'b0000010;
      4'd7:    segPattern = 7'b1111000;
      4'd8:    segPattern = 7'b0000000;
      4'd9:    segPattern = 7'b0010000;
      default: segPattern = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] keyIndex(input logic [8:0] snap);
    keyIndex = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (snap[i]) keyIndex = 4'(i);
    end
  endfunction

  logic [27:0]   counterQ, counterD;
  logic [6:0]    hexQ, hexD;
  logic [SW-1:0] scanCntQ, scanCntD;
  logic [2:0]    columnQ, columnD;
  logic [8:0]    snapAccQ, snapAccD;
  logic [8:0]    prevSnapQ, prevSnapD;
  logic [DW-1:0] debCntQ, debCntD;
  logic          armedQ, armedD;
  logic [3:0]    keyQ, keyD;
  logic          validQ, validD;

  logic [8:0]    sampleBits;
  logic [8:0]    fullSnap;
  logic [DW-1:0] debNext;

  always_comb begin
    counterD = counterQ;
    if (bus.div_enable) begin
      counterD = (counterQ == 28'd0) ? bus.counter_max : counterQ - 28'd1;
    end
    hexD = bus.dec_enable ? segPattern(bus.binary) : hexQ;
  end

  // Bit 3*r+c of a snapshot is row r seen while column c is driven.
  always_comb begin
    sampleBits = 9'd0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        sampleBits[3*r+c] = bus.row[r] & columnQ[c];
      end
    end
    fullSnap = snapAccQ | sampleBits;
    if (fullSnap == prevSnapQ) begin
      debNext = (debCntQ == DEB_MAX) ? DEB_MAX : debCntQ + DW'(1);
    end else begin
      debNext = DW'(1);
    end
  end

  always_comb begin
    scanCntD  = scanCntQ + SW'(1);
    columnD   = columnQ;
    snapAccD  = snapAccQ;
    prevSnapD = prevSnapQ;
    debCntD   = debCntQ;
    armedD    = armedQ;
    keyD      = keyQ;
    validD    = 1'b0;
    if (scanCntQ == SCAN_LAST) begin
      scanCntD = '0;
      columnD  = {columnQ[1:0], columnQ[2]};
      snapAccD = snapAccQ | sampleBits;
      // The sample on the last column closes a full scan and drives the debounce decision.
      if (columnQ[2]) begin
        snapAccD  = 9'd0;
        prevSnapD = fullSnap;
        debCntD   = debNext;
        if (debNext == DEB_MAX) begin
          if ($onehot(fullSnap) && armedQ) begin
            keyD   = keyIndex(fullSnap);
            validD = 1'b1;
            armedD = 1'b0;
          end else if (fullSnap == 9'd0) begin
            armedD = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counterQ  <= bus.counter_max;
      hexQ      <= 7'b1111111;
      scanCntQ  <= '0;
      columnQ   <= 3'b001;
      snapAccQ  <= 9'd0;
      prevSnapQ <= 9'd0;
      debCntQ   <= '0;
      armedQ    <= 1'b1;
      keyQ      <= 4'd0;
      validQ    <= 1'b0;
    end else begin
      counterQ  <= counterD;
      hexQ      <= hexD;
      scanCntQ  <= scanCntD;
      columnQ   <= columnD;
      snapAccQ  <= snapAccD;
      prevSnapQ <= prevSnapD;
      debCntQ   <= debCntD;
      armedQ    <= armedD;
      keyQ      <= keyD;
      validQ    <= validD;
    end
  end

  assign bus.counter   = counterQ;
  assign bus.tick      = bus.div_enable && (counterQ == 28'd0);
  assign bus.hex       = hexQ;
  assign bus.column    = columnQ;
  assign bus.key       = keyQ;
  assign bus.valid_key = validQ;

endmodule

// File: tb/tb_keypad_tick_display_unit.sv
// Self-checking bench for keypad_tick_display_unit: divider model, decoder vector table,
// and a key scoreboard fed by a behavioural 3x3 matrix model.
module tb_keypad_tick_display_unit;

  localparam int SCAN = 4;
  localparam int DEB  = 2;
  localparam int FULL_SCAN = 3 * SCAN;

  typedef struct {
    logic [3:0] binary;
    logic       decEnable;
    logic [6:0] expHex;
  } decVector_t;

  logic clk = 1'b0;
  logic reset;
  logic [8:0] pressedMask = 9'd0;
  logic [2:0] rowDrive;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleNum = 0;
  int pulseCount = 0;
  int lastPulseCycle = 0;
  int releaseCycle = 0;
  int expCount;
  logic [3:0] keyQueue[$];
  logic [6:0] hexQueue[$];
  logic [3:0] monitorExpKey;
  decVector_t decTable[15];

  keypad_tick_display_unit_if bus();

  keypad_tick_display_unit #(
    .SCAN_CYCLES(SCAN),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // A pressed key connects its row to its column whenever that column is driven.
  always_comb begin
    rowDrive = 3'b000;
    for (int r = 0; r < 3; r++) begin
      rowDrive[r] = |(pressedMask[3*r +: 3] & bus.column);
    end
  end
  assign bus.row = rowDrive;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] binary, input logic decEnable);
    bus.binary = binary;
    bus.dec_enable = decEnable;
  endtask

  task automatic waitForKeys(input string name, input int budget);
    int n;
    n = 0;
    while (keyQueue.size() != 0 && n < budget) begin
      waitCycles(1);
      n++;
    end
    checkOutput(name, keyQueue.size(), 0);
    keyQueue.delete();
  endtask

  // Every valid_key pulse must match the oldest expected key; any extra pulse is an error.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.valid_key === 1'b1) begin
      pulseCount++;
      lastPulseCycle = cycleNum;
      if (keyQueue.size() == 0) begin
        checkOutput("unexpectedPulse", 1, 0);
      end else begin
        monitorExpKey = keyQueue.pop_front();
        checkOutput("scanKey", bus.key, monitorExpKey);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    decTable[0]  = '{4'd0,  1'b1, 7'b1000000};
    decTable[1]  = '{4'd1,  1'b1, 7'b1111001};
    decTable[2]  = '{4'd2,  1'b1, 7'b0100100};
    decTable[3]  = '{4'd3,  1'b1, 7'b0110000};
    decTable[4]  = '{4'd4,  1'b1, 7'b0011001};
    decTable[5]  = '{4'd5,  1'b1, 7'b0010010};
    decTable[6]  = '{4'd6,  1'b1, 7'b0000010};
    decTable[7]  = '{4'd7,  1'b1, 7'b1111000};
    decTable[8]  = '{4'd8,  1'b1, 7'b0000000};
    decTable[9]  = '{4'd9,  1'b1, 7'b0010000};
    decTable[10] = '{4'd12, 1'b1, 7'b1111111};
    decTable[11] = '{4'd3,  1'b0, 7'b1111111};
    decTable[12] = '{4'd8,  1'b1, 7'b0000000};
    decTable[13] = '{4'd1,  1'b0, 7'b0000000};
    decTable[14] = '{4'd15, 1'b1, 7'b1111111};

    reset = 1'b1;
    bus.counter_max = 28'd4;
    bus.div_enable = 1'b1;
    applyStimulus(4'd0, 1'b0);
    waitCycles(2);

    checkOutput("rstCounter", bus.counter, 4);
    checkOutput("rstTick", bus.tick, 0);
    checkOutput("rstHex", bus.hex, 7'h7F);
    checkOutput("rstColumn", bus.column, 3'b001);
    checkOutput("rstKey", bus.key, 0);
    checkOutput("rstValid", bus.valid_key, 0);

    $display("[TB] divider");
    reset = 1'b0;
    expCount = 4;
    for (int i = 0; i < 12; i++) begin
      checkOutput("divCount", bus.counter, expCount);
      checkOutput("divTick", bus.tick, 32'(expCount == 0));
      waitCycles(1);
      expCount = (expCount == 0) ? int'(bus.counter_max) : expCount - 1;
    end
    bus.div_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("divHoldCount", bus.counter, expCount);
      checkOutput("divHoldTick", bus.tick, 0);
      waitCycles(1);
    end
    bus.div_enable = 1'b1;
    bus.counter_max = 28'd2;
    for (int i = 0; i < 8; i++) begin
      checkOutput("divNewMaxCount", bus.counter, expCount);
      checkOutput("divNewMaxTick", bus.tick, 32'(expCount == 0));
      waitCycles(1);
      expCount = (expCount == 0) ? int'(bus.counter_max) : expCount - 1;
    end

    $display("[TB] decoder");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(decTable[i].binary, decTable[i].decEnable);
      hexQueue.push_back(decTable[i].expHex);
      waitCycles(1);
      checkOutput($sformatf("hex[%0d]", i), bus.hex, hexQueue.pop_front());
    end
    applyStimulus(4'd0, 1'b0);

    $display("[TB] scanner single key");
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    releaseCycle = cycleNum;
    pressedMask = 9'h020;
    keyQueue.push_back(4'd5);
    waitForKeys("key5Accept", 40);
    checkOutput("key5Latency", lastPulseCycle - releaseCycle, DEB * FULL_SCAN);
    checkOutput("key5Value", bus.key, 5);
    waitCycles(60);
    checkOutput("heldNoRepeat", pulseCount, 1);

    $display("[TB] scanner re-arm");
    pressedMask = 9'h000;
    waitCycles(3 * FULL_SCAN);
    checkOutput("keyHoldsAfterRelease", bus.key, 5);
    pressedMask = 9'h001;
    keyQueue.push_back(4'd0);
    waitForKeys("key0Accept", 60);
    checkOutput("key0Value", bus.key, 0);
    checkOutput("pulsesAfterKey0", pulseCount, 2);

    $display("[TB] scanner multi key");
    pressedMask = 9'h000;
    waitCycles(3 * FULL_SCAN);
    pressedMask = 9'h101;
    waitCycles(60);
    checkOutput("multiKeyNoPulse", pulseCount, 2);
    pressedMask = 9'h000;
    waitCycles(3 * FULL_SCAN);

    $display("[TB] scanner bounce");
    for (int i = 0; i < 6; i++) begin
      pressedMask = (i % 2 == 0) ? 9'h010 : 9'h000;
      waitCycles(FULL_SCAN);
    end
    checkOutput("bounceNoPulse", pulseCount, 2);
    pressedMask = 9'h010;
    keyQueue.push_back(4'd4);
    waitForKeys("key4Accept", 50);
    checkOutput("key4Value", bus.key, 4);
    checkOutput("pulsesAfterKey4", pulseCount, 3);

    $display("[TB] reset mid-operation");
    bus.counter_max = 28'd7;
    applyStimulus(4'd8, 1'b1);
    waitCycles(1);
    applyStimulus(4'd8, 1'b0);
    checkOutput("hexBeforeReset", bus.hex, 7'h00);
    waitCycles(5);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("midRstColumn", bus.column, 3'b001);
    checkOutput("midRstKey", bus.key, 0);
    checkOutput("midRstValid", bus.valid_key, 0);
    checkOutput("midRstHex", bus.hex, 7'h7F);
    checkOutput("midRstCounter", bus.counter, 7);
    checkOutput("midRstTick", bus.tick, 0);
    bus.counter_max = 28'd0;
    waitCycles(1);
    checkOutput("rstMaxZeroCounter", bus.counter, 0);
    checkOutput("rstMaxZeroTick", bus.tick, 1);
    reset = 1'b0;
    releaseCycle = cycleNum;
    keyQueue.push_back(4'd4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("maxZeroTick", bus.tick, 1);
      checkOutput("maxZeroCounter", bus.counter, 0);
      waitCycles(1);
    end
    waitForKeys("armedAfterReset", 40);
    checkOutput("armedAfterResetLatency", lastPulseCycle - releaseCycle, DEB * FULL_SCAN);
    checkOutput("armedAfterResetKey", bus.key, 4);
    checkOutput("finalPulseCount", pulseCount, 4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/keypad_tick_display_unit.md
# keypad_tick_display_unit

Shared I/O support block for the whole-a-mole game. It contains:
- a programmable tick divider that paces the ready countdown;
- a single-digit binary-to-7-segment decoder for the countdown HEX display;
- a 3×3 key-matrix scanner with debounce that reports which of the nine buttons was struck.

The three functions share one clock and one reset and are otherwise independent.

## Interface
- `SCAN_CYCLES`, default 50_000: cycles each column is driven before advancing (≥2).
- `DEBOUNCE_SCANS`, default 3: consecutive identical full scans needed to accept a key (≥1).
- `clk` input 1: system clock (CLOCK_50). One clock; reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high; clears all state.
- `counter_max` input 28: divider terminal value; period is counter_max+1 cycles.
- `div_enable` input 1: divider runs while high and holds while low.
- `counter` output 28: current divider count.
- `tick` output 1: combinational; high when div_enable=1 and counter==0.
- `binary` input 4: value to display.
- `dec_enable` input 1: load the display register.
- `hex` output 7: active-low segments, bit0=a … bit6=g.
- `row` input 3: matrix row sense, active-high (externally pulled low).
- `column` output 3: one-hot column drive.
- `key` output 4: index of the last accepted key, 0–8.
- `valid_key` output 1: one-cycle pulse on key acceptance.

## Operation
- **Divider**
  - Down-counter.
  - Reset: counter=counter_max.
  - Each enabled cycle: if counter==0, reload counter_max; else decrement.
  - Disabled: hold.
  - counter_max is sampled only at reload and reset.
  - counter_max=0: tick is high on every enabled cycle.
- **Decoder**
  - Registered output.
  - Reset: hex=7'b1111111 (blank).
  - When dec_enable=1, hex takes the pattern for binary on the next edge; otherwise hex holds.
  - Patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - binary values 10–15 produce blank.
- **Scanner**
  - column rotates 001→010→100→001, dwelling SCAN_CYCLES cycles on each.
  - row is sampled on the last cycle of each dwell.
  - Key index = 3*r + c for row[r] with column[c] active.
  - Sampling all three columns forms a 9-bit snapshot; one full scan is 3*SCAN_CYCLES cycles.
  - Debounce counter:
    - increments when a snapshot equals the previous snapshot;
    - is set to 1 otherwise;
    - saturates at DEBOUNCE_SCANS.
  - Acceptance requires all of: debounce count reaches DEBOUNCE_SCANS; the snapshot has exactly one bit set; the scanner is armed.
  - On acceptance: key ← index, valid_key pulses once, scanner disarms.
  - Re-arm occurs only after a stable all-zero snapshot (DEBOUNCE_SCANS consecutive all-zero scans).
  - A held key never repeats.
  - Snapshots with two or more keys are never accepted and do not re-arm.
  - key holds its value until the next acceptance.
- **Reset mid-operation**
  - Abandons the partial scan and disarms nothing: after reset the scanner is armed.
  - Debounce history and the previous snapshot are cleared to zero.

## Timing
- Reset values:
  - counter=counter_max, tick=div_enable&&(counter_max==0)
  - hex=7'b1111111
  - column=3'b001, key=0, valid_key=0
  - scan cycle count=0, debounce count=0, snapshot=0, armed=1
- Divider: with div_enable held high after reset, tick is high for one cycle every counter_max+1 cycles. The first tick occurs counter_max cycles after reset release.
- Decoder: 1-cycle latency from dec_enable to hex.
- Scanner:
  - column changes on the edge after the sampling cycle.
  - A snapshot completes on the sample of column 100.
  - valid_key asserts on the edge following the completing sample and lasts exactly one cycle.
  - key updates on that same edge.
  - Minimum press-to-valid_key latency, with the key stable before a scan starts: DEBOUNCE_SCANS*3*SCAN_CYCLES cycles (+1).
- Simultaneous events: the three sub-blocks never interact. Reset dominates every enable.

## Test plan
- Divider: counter_max=4, div_enable=1 → tick high once every 5 cycles; counter sequence 4,3,2,1,0,4. Drop div_enable for 3 cycles → counter holds and no tick.
- Decoder: drive binary 0–9 with dec_enable=1 → listed patterns one cycle later. binary=12 → 1111111. dec_enable=0 with binary changing → hex holds.
- Scanner: SCAN_CYCLES=4, DEBOUNCE_SCANS=2, key 5 held (row[1] high while column=100) → exactly one valid_key pulse with key=5 about 24 cycles after press. Continue holding → no further pulses.
- Release, then press key 0 → re-arm after 2 clean scans, then pulse with key=0. Keys 0 and 8 pressed together → no pulse.
- Bounce: toggle row every scan → no pulse until the row is stable for 2 scans.
- Reset asserted mid-scan → column=001, key=0, valid_key=0, hex blank, counter=counter_max on the next cycle.
